// File: rtl/div_repeated_sub.sv
// Sequential divider: repeated subtraction of the divisor from the dividend.
// Controller FSM plus datapath (R remainder reg, B divisor reg, Q quotient counter).
// Operands share data_in: dividend in the start cycle, divisor in the next cycle.
// Optional feature macro: DIV_SIGNED_EN (two's complement operands, truncating division).
module div_repeated_sub #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    typedef enum logic [1:0] {StIdle, StLoadB, StSub, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] op_in;
    logic             r_ge_b;

`ifdef DIV_SIGNED_EN
    logic sign_in;
    logic sa_q, sa_d;
    logic sb_q, sb_d;

    // Operand magnitude; most-negative maps onto itself, which is its correct unsigned magnitude
    always_comb begin
        sign_in = data_in[WIDTH-1];
        op_in   = sign_in ? -data_in : data_in;
    end
`else
    // Unsigned build: operands are used as-is
    always_comb begin
        op_in = data_in;
    end
`endif

    assign r_ge_b = (r_q >= b_q);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            r_q     <= '0;
            b_q     <= '0;
            q_q     <= '0;
            dbz_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            b_q     <= b_d;
            q_q     <= q_d;
            dbz_q   <= dbz_d;
`ifdef DIV_SIGNED_EN
            sa_q    <= sa_d;
            sb_q    <= sb_d;
`endif
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        b_d     = b_q;
        q_d     = q_q;
        dbz_d   = dbz_q;
`ifdef DIV_SIGNED_EN
        sa_d    = sa_q;
        sb_d    = sb_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    r_d     = op_in;
                    q_d     = '0;
                    dbz_d   = 1'b0;
`ifdef DIV_SIGNED_EN
                    sa_d    = sign_in;
`endif
                    state_d = StLoadB;
                end
            end
            StLoadB: begin
                b_d = op_in;
`ifdef DIV_SIGNED_EN
                sb_d = sign_in;
`endif
                if (data_in == '0) begin
                    dbz_d   = 1'b1;
                    q_d     = '1;
                    state_d = StDone;
                end else begin
                    state_d = StSub;
                end
            end
            StSub: begin
                // Compare gates the subtract, so R never underflows
                if (r_ge_b) begin
                    r_d = r_q - b_q;
                    q_d = q_q + WIDTH'(1);
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Status decodes and result outputs
    always_comb begin
        busy        = (state_q == StLoadB) || (state_q == StSub);
        done        = (state_q == StDone);
        div_by_zero = dbz_q;
`ifdef DIV_SIGNED_EN
        // Divide-by-zero keeps all-ones quotient; remainder follows dividend sign
        quotient    = (!dbz_q && (sa_q ^ sb_q)) ? -q_q : q_q;
        remainder   = sa_q ? -r_q : r_q;
`else
        quotient    = q_q;
        remainder   = r_q;
`endif
    end

endmodule

// File: tb/tb_div_repeated_sub.sv
// Directed bench for div_repeated_sub with an expected-result scoreboard queue.
module tb_div_repeated_sub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [15:0] data_in = '0;
    logic        busy, done, div_by_zero;
    logic [15:0] quotient, remainder;

    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        dbz;
        int          edges;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    div_repeated_sub #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data_in     (data_in),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one operation; expected results go to the scoreboard at drive time
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] eq, input logic [15:0] er, input logic edbz,
                          input int eedge, input int poke);
        exp_t e;
        int   n;
        int   busy_cnt;
        int   overlap;
        e.q = eq;
        e.r = er;
        e.dbz = edbz;
        e.edges = eedge;
        sb.push_back(e);
        start = 1'b1;
        data_in = a;
        tick;  // edge 0
        check({tag, "_busy_e0"}, busy, 1);
        check({tag, "_done_e0"}, done, 0);
        busy_cnt = busy ? 1 : 0;
        overlap = 0;
        start = 1'b0;
        data_in = b;
        tick;  // edge 1
        n = 1;
        while (!done && n < eedge + 20) begin
            if (busy) busy_cnt++;
            start = (n == poke);
            data_in = (n == poke) ? 16'h1234 : b;
            tick;
            n++;
            if (busy && done) overlap++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, "_done"}, done, 1);
        check({tag, "_edges"}, n, e.edges);
        check({tag, "_q"}, quotient, e.q);
        check({tag, "_r"}, remainder, e.r);
        check({tag, "_dbz"}, div_by_zero, e.dbz);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_busy_cycles"}, busy_cnt, e.edges);
        check({tag, "_overlap"}, overlap, 0);
    endtask

    initial begin
        // Power-on reset
        #2 rst_n = 1'b0;
        tick;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        rst_n = 1'b1;

        // Reset mid-SUB: 1000/3, reset after edge 10
        start = 1'b1;
        data_in = 16'd1000;
        tick;
        start = 1'b0;
        data_in = 16'd3;
        tick;
        repeat (9) tick;
        check("midsub_busy_before", busy, 1);
        check("midsub_q_before", quotient, 9);
        rst_n = 1'b0;
        #1;
        check("midsub_rst_busy", busy, 0);
        check("midsub_rst_done", done, 0);
        check("midsub_rst_q", quotient, 0);
        check("midsub_rst_r", remainder, 0);
        #1 rst_n = 1'b1;
        run_op("d7_2", 16'd7, 16'd2, 16'd3, 16'd1, 1'b0, 5, -1);

        run_op("d100_7", 16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16, -1);
        // Results hold in DONE while start stays low
        repeat (3) tick;
        check("hold_done", done, 1);
        check("hold_q", quotient, 14);
        check("hold_r", remainder, 2);

        run_op("d5_9", 16'd5, 16'd9, 16'd0, 16'd5, 1'b0, 2, -1);
        run_op("d0_4", 16'd0, 16'd4, 16'd0, 16'd0, 1'b0, 2, -1);
        run_op("d1234_56", 16'd1234, 16'd56, 16'd22, 16'd2, 1'b0, 24, -1);
        run_op("d42_0", 16'd42, 16'd0, 16'hFFFF, 16'd42, 1'b0 | 1'b1, 1, -1);
        // Back-to-back restart straight from DONE clears the flag
        run_op("d42_6", 16'd42, 16'd6, 16'd7, 16'd0, 1'b0, 9, -1);

`ifdef DIV_SIGNED_EN
        run_op("s_m1_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 3, -1);
        run_op("s_m17_5", 16'hFFEF, 16'd5, 16'hFFFD, 16'hFFFE, 1'b0, 5, -1);
        run_op("s_17_m5", 16'd17, 16'hFFFB, 16'hFFFD, 16'd2, 1'b0, 5, -1);
        run_op("s_m42_0", 16'hFFD6, 16'd0, 16'hFFFF, 16'hFFD6, 1'b1, 1, -1);
        run_op("s_min_m1", 16'h8000, 16'hFFFF, 16'h8000, 16'd0, 1'b0, 32770, -1);
`else
        // Worst case, with a start pulse during SUB that must be ignored
        run_op("d_ffff_1", 16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 65537, 100);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
